// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared types and constants for the instruction fetch responder.
//   - fetch_state_e : request FSM states (IDLE, WAIT, DROP)
//   - fetch_entry_t : one buffered fetch result {pc, instr} at the default
//                     32-bit width
//   - NOP_INSTR     : instruction shown to decode when nothing is valid
//                     (addi x0, x0, 0)
package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // free to issue the next fetch
    WAIT = 2'd1,  // one fetch outstanding, its response will be kept
    DROP = 2'd2   // one fetch outstanding, its response will be discarded
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Small synchronous FIFO holding fetched {pc, instr} entries.
//   Ports:
//     i_clk    clock, rising edge
//     i_reset  asynchronous active-high reset (empties the FIFO)
//     i_push   write i_din at the tail (ignored when full unless popping)
//     i_pop    drop the head entry (ignored when empty)
//     i_flush  empty the FIFO at the edge; wins over push and pop
//     i_din    entry to write
//     o_head   current head entry (meaningful when o_count != 0)
//     o_count  number of stored entries, 0..DEPTH
//   DEPTH must be a power of two (pointers wrap naturally) and at least 2.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_din,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  // A simultaneous pop frees a slot, so a push into a full FIFO is still
  // accepted in that case.
  assign wr_en = i_push && !i_flush && (!full || i_pop);
  assign rd_en = i_pop && !i_flush && !empty;

  // Storage carries no reset: only entries below count_reg are ever read.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= i_din;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (i_flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign o_head  = mem[rd_ptr_reg];
  assign o_count = count_reg;

endmodule

// File: rtl/inst_fetch_responder.sv
// inst_fetch_responder
//   Fetch stage glue between the PC register, instruction memory and decode.
//   Issues one word fetch at a time, buffers responses with their PC in a
//   small FIFO and hands them to decode over valid/ready.
//   Ports:
//     i_clk          clock, rising edge
//     i_reset        asynchronous active-high reset
//     i_pc           current PC
//     i_redirect     branch/jump taken this cycle
//     o_pc_en        PC load enable (1 = advance/load, 0 = hold)
//     o_mem_req      one-cycle fetch request strobe
//     o_mem_addr     word-aligned fetch address
//     i_mem_ack      fetch response valid
//     i_mem_rdata    fetched instruction word
//     o_inst_valid   instruction available to decode
//     o_inst         instruction (NOP when not valid)
//     o_inst_pc      PC of o_inst (0 when not valid)
//     i_dec_ready    decode accepts o_inst
//   Build option:
//     FETCH_BYPASS_EN  when defined, a response arriving while the FIFO is
//                      empty is shown to decode in the same cycle as the ack
//                      and skips the FIFO if decode takes it immediately.
module inst_fetch_responder
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_redirect,
  output logic            o_pc_en,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ack,
  input  logic [XLEN-1:0] i_mem_rdata,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  input  logic            i_dec_ready
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 2 * XLEN;

  fetch_state_e      state_reg;
  fetch_state_e      state_next;
  logic [XLEN-1:0]   req_pc_reg;

  logic              issue;
  logic              pc_en;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic [EW-1:0]     fifo_din;
  logic [EW-1:0]     fifo_head;
  logic [CW-1:0]     fifo_count;
  logic              fifo_nonempty;
  logic              bypass_valid;
  logic [EW-1:0]     out_entry;

  // --------------------------------------------------------------------
  // State and request-PC registers
  // --------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg  <= IDLE;
      req_pc_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (issue) begin
        req_pc_reg <= i_pc;
      end
    end
  end

  assign fifo_nonempty = (fifo_count != '0);

`ifdef FETCH_BYPASS_EN
  // Response can go straight to decode when nothing is queued ahead of it.
  assign bypass_valid = !i_reset && !i_redirect && (state_reg == WAIT) &&
                        i_mem_ack && !fifo_nonempty;
`else
  assign bypass_valid = 1'b0;
`endif

  // --------------------------------------------------------------------
  // Next state, issue and FIFO control
  // --------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    pc_en      = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    // Outputs stay quiet while reset is held, not just after the edge.
    if (!i_reset) begin
      if (i_redirect) begin
        // Let the target load, drop everything buffered, and arrange for
        // any in-flight response to be thrown away.
        pc_en      = 1'b1;
        fifo_flush = 1'b1;
        case (state_reg)
          WAIT:    state_next = i_mem_ack ? IDLE : DROP;
          default: state_next = state_reg;
        endcase
      end else begin
        case (state_reg)
          IDLE: begin
            // Only issue when the response is guaranteed a FIFO slot.
            if (fifo_count < CW'(DEPTH)) begin
              issue      = 1'b1;
              pc_en      = 1'b1;
              state_next = WAIT;
            end
          end
          WAIT: begin
            if (i_mem_ack) begin
              // A bypassed response taken by decode never enters the FIFO.
              fifo_push  = !(bypass_valid && i_dec_ready);
              state_next = IDLE;
            end
          end
          DROP: begin
            if (i_mem_ack) begin
              state_next = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end
  end

  // Redirect suppresses the pop: the head is being flushed anyway and decode
  // must not see it.
  assign fifo_pop = !i_reset && !i_redirect && fifo_nonempty && i_dec_ready;
  assign fifo_din = {req_pc_reg, i_mem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (fifo_push),
    .i_pop   (fifo_pop),
    .i_flush (fifo_flush),
    .i_din   (fifo_din),
    .o_head  (fifo_head),
    .o_count (fifo_count)
  );

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign o_pc_en    = pc_en;
  assign o_mem_req  = issue;
  assign o_mem_addr = issue ? {i_pc[XLEN-1:2], 2'b00} : '0;

  assign o_inst_valid = !i_reset && !i_redirect && (fifo_nonempty || bypass_valid);

  // Bypass only happens with an empty FIFO, so the two sources never compete.
  assign out_entry = bypass_valid ? fifo_din : fifo_head;

  assign o_inst    = o_inst_valid ? out_entry[XLEN-1:0]    : XLEN'(NOP_INSTR);
  assign o_inst_pc = o_inst_valid ? out_entry[EW-1:XLEN]   : '0;

endmodule

// File: tb/tb_inst_fetch_responder.sv
module tb_inst_fetch_responder;

  localparam int DEPTH  = 4;
  localparam int XLEN   = 32;
  localparam int NCYC   = 3000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic [XLEN-1:0] i_pc;
  logic            i_redirect;
  logic            o_pc_en;
  logic            o_mem_req;
  logic [XLEN-1:0] o_mem_addr;
  logic            i_mem_ack;
  logic [XLEN-1:0] i_mem_rdata;
  logic            o_inst_valid;
  logic [XLEN-1:0] o_inst;
  logic [XLEN-1:0] o_inst_pc;
  logic            i_dec_ready;

  inst_fetch_responder #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_pc         (i_pc),
    .i_redirect   (i_redirect),
    .o_pc_en      (o_pc_en),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata),
    .o_inst_valid (o_inst_valid),
    .o_inst       (o_inst),
    .o_inst_pc    (o_inst_pc),
    .i_dec_ready  (i_dec_ready)
  );

  always #5 i_clk = ~i_clk;

  // Expected instruction stream: every accepted response in order, with the
  // first cycle in which decode may see it.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          avail;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------
  // Monitor: compares the decode-side output against the scoreboard.
  // ------------------------------------------------------------------
  initial begin
    logic exp_valid;
    forever begin
      @(negedge i_clk);
      exp_valid = !i_reset && !i_redirect && (q.size() > 0) && (q[0].avail <= cyc);
      check("inst_valid", {31'b0, o_inst_valid}, {31'b0, exp_valid});
      if (o_inst_valid && exp_valid) begin
        check("inst", o_inst, q[0].instr);
        check("inst_pc", o_inst_pc, q[0].pc);
        if (i_dec_ready) begin
          $display("[TB] cyc %0d decode took pc=%h inst=%h", cyc, o_inst_pc, o_inst);
          void'(q.pop_front());
        end
      end else if (!o_inst_valid) begin
        check("idle_inst", o_inst, 32'h00000013);
        check("idle_pc", o_inst_pc, 32'h0);
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus + memory model + request-side checks.
  // ------------------------------------------------------------------
  initial begin
    bit          pending;   // a fetch is in flight
    bit          dropping;  // its response must be discarded
    bit          stray;     // inject an ack that belongs to no request
    bit          exp_issue;
    bit          ack;
    bit          redir;
    int          timer;
    logic [31:0] req_pc;
    logic [31:0] pc;
    logic [31:0] rdata;

    pending = 0; dropping = 0; stray = 0; timer = 0; req_pc = '0;
    i_reset = 1'b1; i_pc = '0; i_redirect = 1'b0; i_mem_ack = 1'b0;
    i_mem_rdata = '0; i_dec_ready = 1'b0;

    repeat (2) @(posedge i_clk);
    #1;
    check("rst_mem_req", {31'b0, o_mem_req}, 32'h0);
    check("rst_pc_en", {31'b0, o_pc_en}, 32'h0);
    check("rst_addr", o_mem_addr, 32'h0);
    check("rst_valid", {31'b0, o_inst_valid}, 32'h0);
    check("rst_inst", o_inst, 32'h00000013);
    check("rst_inst_pc", o_inst_pc, 32'h0);

    for (int n = 0; n < NCYC; n++) begin
      @(posedge i_clk);
      cyc++;
      #1;

      // Occasional reset while a kept fetch is outstanding.
      if (n > 20 && pending && !dropping && $urandom_range(0, 59) == 0) begin
        i_reset = 1'b1; i_redirect = 1'b0; i_mem_ack = 1'b0;
        q.delete();
        pending = 0; dropping = 0; stray = 1;
        @(negedge i_clk);
        check("inrst_mem_req", {31'b0, o_mem_req}, 32'h0);
        check("inrst_pc_en", {31'b0, o_pc_en}, 32'h0);
        check("inrst_addr", o_mem_addr, 32'h0);
        $display("[TB] cyc %0d reset pulse", cyc);
        continue;
      end
      i_reset = 1'b0;

      // Cycles 1000..1099 hold decode off to fill the FIFO.
      if (n >= 1000 && n < 1100) i_dec_ready = 1'b0;
      else                       i_dec_ready = ($urandom_range(0, 9) < 6);

      ack   = (pending && timer == 0) || stray;
      redir = ($urandom_range(0, 9) == 0) && !(n >= 1000 && n < 1100);
      // A redirect landing on the very ack that ends a DROP would leave the
      // responder waiting for an ack that never comes; keep that out.
      if (dropping && ack) redir = 0;
      pc    = $urandom;
      rdata = stray ? 32'hDEADBEEF : $urandom;

      exp_issue = !redir && !pending && (q.size() < DEPTH);

      if (pending && ack) begin
        if (!dropping && !redir) begin
          q.push_back('{req_pc, rdata, (BYPASS && q.size() == 0) ? cyc : cyc + 1});
        end
        pending = 0; dropping = 0;
      end else if (pending) begin
        if (redir) dropping = 1;
        if (timer > 0) timer--;
      end
      if (redir) q.delete();
      stray = 0;

      i_redirect  = redir;
      i_mem_ack   = ack;
      i_mem_rdata = rdata;
      i_pc        = pc;

      @(negedge i_clk);
      check("mem_req", {31'b0, o_mem_req}, {31'b0, exp_issue});
      check("pc_en", {31'b0, o_pc_en}, {31'b0, exp_issue || redir});
      if (exp_issue) begin
        check("mem_addr", o_mem_addr, {pc[31:2], 2'b00});
        $display("[TB] cyc %0d fetch pc=%h", cyc, pc);
        pending  = 1;
        dropping = 0;
        req_pc   = pc;
        timer    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
